// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode, FSM state and flag-index definitions for alu_mc.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Bit positions inside the {N, Z, C, V} flags vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Shift-add unsigned multiplier, one multiplier bit per cycle.
//               Bit 0 is consumed on the start edge, so done pulses WIDTH-1
//               cycles after start and the product is final while done=1.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int               c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                r_mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                r_mplier <= b >> 1;
                r_cnt    <= c_cnt_w'(1);
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + c_cnt_w'(1);
                if (r_cnt == c_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Multi-cycle ALU with valid/ready handshakes and NZCV flags.
//               Define ALU_MUL_EN to build the iterative multiplier for op 111;
//               otherwise op 111 returns zero with op_err set.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUresult,
    output logic [3:0]       flags,
    output logic             op_err
);

    localparam int c_shamt_w = $clog2(WIDTH);
`ifdef ALU_MUL_EN
    localparam bit c_mul_en = 1'b1;
`else
    localparam bit c_mul_en = 1'b0;
`endif

    alu_state_e r_state;
    alu_state_e w_state_next;

    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_op_err;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_load_op;
    logic               w_load_mul;
    logic               w_mul_start;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [c_shamt_w-1:0] w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic [3:0]         w_flags;
    logic [3:0]         w_mul_flags;

    // ------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------
    assign w_sum   = {1'b0, srcA} + {1'b0, srcB};
    // Carry out of A + ~B + 1 is the "no borrow" indication
    assign w_diff  = {1'b0, srcA} + {1'b0, ~srcB} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = srcB[c_shamt_w-1:0];

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (alu_op_e'(ALUop))
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (srcA[WIDTH-1] != srcB[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (srcA[WIDTH-1] == srcB[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_AND:  w_res = srcA & srcB;
            OP_OR:   w_res = srcA | srcB;
            OP_XOR:  w_res = srcA ^ srcB;
            OP_SLL:  w_res = srcA << w_shamt;
            OP_SRL:  w_res = srcA >> w_shamt;
            default: w_err = !c_mul_en;
        endcase

        w_flags = '0;
        if (!w_err) begin
            w_flags[FLAG_N] = w_res[WIDTH-1];
            w_flags[FLAG_Z] = (w_res == '0);
            w_flags[FLAG_C] = w_c;
            w_flags[FLAG_V] = w_v;
        end
    end

    always_comb begin
        w_mul_flags         = '0;
        w_mul_flags[FLAG_N] = w_mul_product[WIDTH-1];
        w_mul_flags[FLAG_Z] = (w_mul_product[WIDTH-1:0] == '0);
        w_mul_flags[FLAG_C] = |w_mul_product[2*WIDTH-1:WIDTH];
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
`ifdef ALU_MUL_EN
    alu_mul_iter #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (srcA),
        .b       (srcB),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`else
    assign w_mul_busy    = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign in_ready = (r_state == ST_IDLE) && !rst && !w_mul_busy;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_op    = 1'b0;
        w_load_mul   = 1'b0;
        w_mul_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (c_mul_en && (alu_op_e'(ALUop) == OP_MUL)) begin
                        w_state_next = ST_MUL;
                        w_mul_start  = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                        w_load_op    = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_DONE;
                    w_load_mul   = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_op_err    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load_op) begin
                r_result <= w_res;
                r_flags  <= w_flags;
                r_op_err <= w_err;
            end else if (w_load_mul) begin
                r_result <= w_mul_product[WIDTH-1:0];
                r_flags  <= w_mul_flags;
                r_op_err <= 1'b0;
            end
            r_out_valid <= (w_state_next == ST_DONE);
        end
    end

    assign out_valid = r_out_valid;
    assign ALUresult = r_result;
    assign flags     = r_flags;
    assign op_err    = r_op_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Scoreboard testbench for alu_mc (WIDTH=16), either build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUop;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUresult;
    logic [3:0]   flags;
    logic         op_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         err;
        logic [7:0]   lat;
    } exp_t;

    exp_t sb_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUop     (ALUop),
        .srcA      (srcA),
        .srcB      (srcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUresult (ALUresult),
        .flags     (flags),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [W:0]   wide;
        logic         c;
        logic         v;
`ifdef ALU_MUL_EN
        logic [2*W-1:0] p;
`endif
        c     = 1'b0;
        v     = 1'b0;
        e.err = 1'b0;
        e.res = '0;
        e.lat = 8'd1;
        case (op)
            3'd0: begin
                wide  = {1'b0, a} - {1'b0, b};
                e.res = wide[W-1:0];
                c     = (a >= b);
                v     = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd1: begin
                wide  = {1'b0, a} + {1'b0, b};
                e.res = wide[W-1:0];
                c     = wide[W];
                v     = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd4: e.res = a ^ b;
            3'd5: e.res = a << b[3:0];
            3'd6: e.res = a >> b[3:0];
            default: begin
`ifdef ALU_MUL_EN
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                c     = (p[2*W-1:W] != '0);
                e.lat = 8'(W + 1);
`else
                e.err = 1'b1;
`endif
            end
        endcase
        e.fl = e.err ? 4'b0000 : {e.res[W-1], (e.res == '0), c, v};
        return e;
    endfunction

    // Issue one op, wait for its result, hold it for 'hold' cycles, consume it
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_before_issue", in_ready, 1);
        ALUop     = op;
        srcA      = a;
        srcB      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb_q.push_back(model(op, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        ALUop    = ~op;
        srcA     = ~a;
        srcB     = b + 16'd7;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb_q.pop_front();
        check_eq("latency", n, e.lat);
        check_eq("in_ready_busy", in_ready, 0);
        check_eq("result", ALUresult, e.res);
        check_eq("flags", flags, e.fl);
        check_eq("op_err", op_err, e.err);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_result", {ALUresult, flags, op_err}, {e.res, e.fl, e.err});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("consumed_valid", out_valid, 0);
        check_eq("consumed_ready", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUop     = 3'd0;
        srcA      = '0;
        srcB      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_result", ALUresult, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_op_err", op_err, 0);
        rst = 1'b0;
        #1;
        check_eq("ready_after_rst", in_ready, 1);

        run_op(3'd1, 16'h7FFF, 16'h0001, 0);
        run_op(3'd0, 16'h0005, 16'h0005, 2);
        run_op(3'd0, 16'h0003, 16'h0004, 0);
        run_op(3'd5, 16'h0001, 16'h0013, 0);
        run_op(3'd6, 16'h8000, 16'h000F, 1);
        run_op(3'd2, 16'hF0F0, 16'h3C3C, 0);
        run_op(3'd3, 16'hF0F0, 16'h0F01, 0);
        run_op(3'd4, 16'hFFFF, 16'hFFFF, 0);
        run_op(3'd1, 16'h8000, 16'h8000, 0);
        run_op(3'd7, 16'h0100, 16'h0100, 5);
        run_op(3'd7, 16'h1234, 16'h00FF, 0);
        run_op(3'd1, 16'h0002, 16'h0003, 0);

        // Reset in the middle of an op: nothing may come out of it
        ALUop    = 3'd7;
        srcA     = 16'h0003;
        srcB     = 16'h0005;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_result", ALUresult, 0);
        check_eq("abort_op_err", op_err, 0);
        check_eq("abort_in_ready", in_ready, 0);
        rst  = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("abort_no_result", seen, 0);
        run_op(3'd1, 16'h0002, 16'h0003, 0);

        for (int k = 0; k < 12; k++) begin
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
